// File: rtl/mo_line_buffer_reader.sv
// Ping-pong motion-object line buffer pair. One buffer takes sprite pixels
// from the render port while the other is read out to the mixer. Each
// display pixel is erased as it is read, so the buffer comes back clean
// when it next becomes the render buffer. Roles swap on every line start.
module mo_line_buffer_reader #(
    parameter int               PIX_W    = 4,
    parameter logic [PIX_W-1:0] BLANK    = '0,
    parameter logic [7:0]       RD_START = 8'd6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce5,
    input  logic             line_start,
    input  logic             wr_en,
    input  logic [7:0]       wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_active,
    output logic [PIX_W-1:0] pix_out,
    output logic             pix_valid,
    output logic             bank,
    output logic             ready
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] clr_addr_q, clr_addr_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic       bank_q, bank_d;
    logic       pix_valid_q, pix_valid_d;

    logic       in_clear;
    logic       in_run;
    logic       rd_fire;
    logic       render_fire;

    // Registered read word of each buffer, exported from the generate blocks.
    logic [PIX_W-1:0] rd_word [2];

    assign in_clear    = ce5 && (state_q == ST_CLEAR);
    assign in_run      = ce5 && (state_q == ST_RUN);
    // A line-start tick swaps roles and suppresses the read/erase entirely.
    assign rd_fire     = in_run && !line_start && rd_active;
    // Transparent pixels never reach the array so earlier opaque pixels survive.
    assign render_fire = in_run && wr_en && (wr_data != BLANK);

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= 8'd0;
            rd_addr_q   <= RD_START;
            bank_q      <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rd_addr_q   <= rd_addr_d;
            bank_q      <= bank_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    // Next-state: sweep both buffers once, then serve line swaps and readout.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rd_addr_d   = rd_addr_q;
        bank_d      = bank_q;
        pix_valid_d = pix_valid_q;
        if (ce5) begin
            case (state_q)
                ST_CLEAR: begin
                    clr_addr_d = clr_addr_q + 8'd1;
                    if (clr_addr_q == 8'd255) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (line_start) begin
                        bank_d      = ~bank_q;
                        rd_addr_d   = RD_START;
                        pix_valid_d = 1'b0;
                    end else if (rd_active) begin
                        // Natural 8-bit wrap: reading continues from address 0.
                        rd_addr_d   = rd_addr_q + 8'd1;
                        pix_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                end
            endcase
        end
    end

    // One single-write, single-read array per buffer. The display buffer is
    // written (erase) at the same address it reads; read-first behaviour
    // returns the pixel before it is blanked.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            logic [PIX_W-1:0] mem [256];
            logic [PIX_W-1:0] rd_data_q;
            logic             is_display;
            logic             we;
            logic [7:0]       waddr;
            logic [PIX_W-1:0] wdata;
            logic             re;

            assign is_display = (bank_q == 1'(gi));
            assign re         = rd_fire && is_display;

            // Pick the single writer of this buffer for the current tick.
            always_comb begin
                we    = 1'b0;
                waddr = clr_addr_q;
                wdata = BLANK;
                if (in_clear) begin
                    we = 1'b1;
                end else if (is_display) begin
                    we    = rd_fire;
                    waddr = rd_addr_q;
                end else begin
                    we    = render_fire;
                    waddr = wr_addr;
                    wdata = wr_data;
                end
            end

            // Array write and registered read; contents are never reset.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
                if (re) begin
                    rd_data_q <= mem[rd_addr_q];
                end
            end

            assign rd_word[gi] = rd_data_q;
        end
    endgenerate

    // The last read always came from the current display buffer, because a
    // swap clears pix_valid until the new buffer has been read.
    assign pix_out   = pix_valid_q ? rd_word[bank_q] : BLANK;
    assign pix_valid = pix_valid_q;
    assign bank      = bank_q;
    assign ready     = (state_q == ST_RUN);

endmodule
